arcade_input_map: RTL and testbench



---
 rtl/arcade_input_pkg.sv | 18 +
 rtl/input_pulse_stretch.sv | 39 +++
 rtl/arcade_input_map.sv | 129 ++++++++++++
 tb/tb_arcade_input_map.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: map-entry type, default download indices and bit resolver
package arcade_input_pkg;

    typedef struct packed {
        logic       en;
        logic       inv;
        logic       rsvd;
        logic [4:0] sel;
    } map_entry_t;

    localparam logic [7:0] MAP_INDEX_DEF = 8'd2;
    localparam logic [7:0] DIP_INDEX_DEF = 8'd254;

    function automatic logic resolve(logic en, logic inv, logic [4:0] sel, logic [31:0] s1);
        return en & (s1[sel] ^ inv);
    endfunction

endpackage

// File: rtl/input_pulse_stretch.sv
// input_pulse_stretch: holds a rising edge of raw_i high for at least MIN_CYCLES cycles
module input_pulse_stretch #(
    parameter int MIN_CYCLES = 2400000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic raw_i,
    output logic pulse_o
);

    localparam int CW = (MIN_CYCLES > 1) ? $clog2(MIN_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(MIN_CYCLES - 1);

    logic          raw_q;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // a rising edge reloads the hold counter; otherwise it counts down and sticks at zero
    always_comb begin
        cnt_d   = (raw_i & ~raw_q) ? LOAD : ((cnt_q != '0) ? cnt_q - CW'(1) : cnt_q);
        pulse_d = raw_i | (cnt_q != '0);
    end

    // edge detector, counter and stretched output
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            raw_q   <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            raw_q   <= raw_i;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/arcade_input_map.sv
// arcade_input_map: table-driven joystick to cabinet input byte mapper.
// Optional feature macro: INPUT_MAP_SWAP_EN adds the Defender direction-swap mux.
module arcade_input_map
    import arcade_input_pkg::*;
#(
    parameter int          NUM_PORTS       = 3,
    parameter logic [7:0]  MAP_INDEX       = MAP_INDEX_DEF,
    parameter logic [7:0]  DIP_INDEX       = DIP_INDEX_DEF,
    parameter logic [31:0] STRETCH_MASK    = 32'h0000_0400,
    parameter int          COIN_MIN_CYCLES = 2400000,
    parameter int          SWAP_A          = 1,
    parameter int          SWAP_B          = 6
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [24:0]            ioctl_addr,
    input  logic [7:0]             ioctl_dout,
    input  logic [31:0]            joy,
    input  logic                   ctrl_mode,
    input  logic                   dir_state,
    output logic [NUM_PORTS*8-1:0] in_port,
    output logic                   map_valid
);

    localparam int NB = NUM_PORTS * 8;

    map_entry_t    tbl_q [NB];
    map_entry_t    tbl_d [NB];
    logic [7:0]    dip_q [NUM_PORTS];
    logic [7:0]    dip_d [NUM_PORTS];
    logic          valid_q, valid_d;
    logic          map_we, dip_we;
    logic [31:0]   joy_q, str_w, s1_w;
    logic [NB-1:0] map_w, dip_w, port_d, port_q;
    logic          unused_rsvd;

    // download decode: table entries, DIP bytes and the last-entry flag
    always_comb begin
        map_we  = ioctl_wr && (ioctl_index == MAP_INDEX);
        dip_we  = ioctl_wr && (ioctl_index == DIP_INDEX);
        valid_d = valid_q | (map_we && (ioctl_addr == 25'(NB - 1)));
        for (int i = 0; i < NB; i++)
            tbl_d[i] = (map_we && (ioctl_addr == 25'(i))) ? map_entry_t'(ioctl_dout) : tbl_q[i];
        for (int i = 0; i < NUM_PORTS; i++)
            dip_d[i] = (dip_we && (ioctl_addr == 25'(i))) ? ioctl_dout : dip_q[i];
    end

    // stage 1: coin-type bits get a stretcher, the rest are registered directly
    for (genvar b = 0; b < 32; b++) begin : g_s1
        if (STRETCH_MASK[b]) begin : g_str
            input_pulse_stretch #(
                .MIN_CYCLES(COIN_MIN_CYCLES)
            ) u_str (
                .clk_i  (clk_sys),
                .rst_ni (reset_n),
                .raw_i  (joy[b]),
                .pulse_o(str_w[b])
            );
        end else begin : g_raw
            assign str_w[b] = 1'b0;
        end
    end

    assign s1_w = joy_q | str_w;

    // stage 2: resolve every output bit through its table entry; reserved bits are don't-care
    always_comb begin
        unused_rsvd = 1'b0;
        for (int i = 0; i < NB; i++) begin
            map_w[i]    = resolve(tbl_q[i].en, tbl_q[i].inv, tbl_q[i].sel, s1_w);
            unused_rsvd = unused_rsvd ^ tbl_q[i].rsvd;
        end
        for (int p = 0; p < NUM_PORTS; p++)
            dip_w[p*8 +: 8] = dip_q[p];
    end

`ifdef INPUT_MAP_SWAP_EN
    logic          mode_q, dir_q;
    logic [NB-1:0] swp_w;

    // mode and facing are staged with the joystick so all three share the same latency
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            mode_q <= ctrl_mode;
            dir_q  <= dir_state;
        end
    end

    // exchange the two swap slots after resolution, before the DIP OR
    always_comb begin
        swp_w         = map_w;
        swp_w[SWAP_A] = map_w[SWAP_B];
        swp_w[SWAP_B] = map_w[SWAP_A];
    end

    assign port_d = ((mode_q & dir_q) ? swp_w : map_w) | dip_w;
`else
    logic unused_ctrl;

    assign unused_ctrl = ctrl_mode ^ dir_state;
    assign port_d      = map_w | dip_w;
`endif

    // table, DIP, valid flag, stage-1 direct bits and output ports
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB; i++) tbl_q[i] <= '0;
            for (int i = 0; i < NUM_PORTS; i++) dip_q[i] <= '0;
            valid_q <= 1'b0;
            joy_q   <= '0;
            port_q  <= '0;
        end else begin
            for (int i = 0; i < NB; i++) tbl_q[i] <= tbl_d[i];
            for (int i = 0; i < NUM_PORTS; i++) dip_q[i] <= dip_d[i];
            valid_q <= valid_d;
            joy_q   <= joy & ~STRETCH_MASK;
            port_q  <= port_d;
        end
    end

    assign in_port   = port_q;
    assign map_valid = valid_q;

endmodule

// File: tb/tb_arcade_input_map.sv
// tb_arcade_input_map: randomized bench with a behavioural reference model and pinned literal checks
`timescale 1ns/1ps
module tb_arcade_input_map;

    localparam int          NP    = 3;
    localparam int          NB    = NP * 8;
    localparam int          COIN  = 10;
    localparam logic [31:0] SMASK = 32'h0000_0400;
`ifdef INPUT_MAP_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b1;
    logic          ioctl_wr = 1'b0;
    logic [7:0]    ioctl_index = 8'd0;
    logic [24:0]   ioctl_addr = 25'd0;
    logic [7:0]    ioctl_dout = 8'd0;
    logic [31:0]   joy = 32'd0;
    logic          ctrl_mode = 1'b0;
    logic          dir_state = 1'b0;
    logic [NB-1:0] in_port;
    logic          map_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    arcade_input_map #(
        .NUM_PORTS      (NP),
        .COIN_MIN_CYCLES(COIN)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ioctl_wr   (ioctl_wr),
        .ioctl_index(ioctl_index),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .joy        (joy),
        .ctrl_mode  (ctrl_mode),
        .dir_state  (dir_state),
        .in_port    (in_port),
        .map_valid  (map_valid)
    );

    always #5 clk_sys = ~clk_sys;

    // reference model: state as software sees it, plus per-bit time of the last rising edge
    logic [7:0]    m_tbl [NB];
    logic [7:0]    m_dip [NP];
    logic          m_valid;
    logic [NB-1:0] m_port;
    logic [31:0]   m_s1, m_prev;
    logic          m_swap;
    int            cyc;
    int            last_rise [32];

    function automatic logic [NB-1:0] model_port();
        logic [NB-1:0] v;
        logic t;
        v = '0;
        for (int i = 0; i < NB; i++)
            v[i] = m_tbl[i][7] && (m_s1[m_tbl[i][4:0]] ^ m_tbl[i][6]);
        if (m_swap) begin
            t    = v[1];
            v[1] = v[6];
            v[6] = t;
        end
        for (int p = 0; p < NP; p++)
            v[p*8 +: 8] = v[p*8 +: 8] | m_dip[p];
        return v;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NB; i++) m_tbl[i] = 8'd0;
            for (int i = 0; i < NP; i++) m_dip[i] = 8'd0;
            for (int i = 0; i < 32; i++) last_rise[i] = -1000;
            m_valid = 1'b0;
            m_port  = '0;
            m_s1    = '0;
            m_prev  = '0;
            m_swap  = 1'b0;
            cyc     = 0;
        end else begin
            m_port = model_port();
            if (ioctl_wr && ioctl_index == 8'd2 && ioctl_addr < 25'(NB)) begin
                m_tbl[int'(ioctl_addr)] = ioctl_dout;
                if (ioctl_addr == 25'(NB - 1)) m_valid = 1'b1;
            end
            if (ioctl_wr && ioctl_index == 8'd254 && ioctl_addr < 25'(NP))
                m_dip[int'(ioctl_addr)] = ioctl_dout;
            cyc++;
            for (int b = 0; b < 32; b++) begin
                if (joy[b] && !m_prev[b]) last_rise[b] = cyc;
                m_s1[b] = SMASK[b] ? (joy[b] || (cyc - last_rise[b] < COIN)) : joy[b];
            end
            m_prev = joy;
            m_swap = SWAP && ctrl_mode && dir_state;
        end
    end

    always @(negedge clk_sys) begin
        if (chk_en) begin
            checks++;
            if (in_port !== m_port || map_valid !== m_valid) begin
                errors++;
                $display("FAIL model in_port=%h map_valid=%b expected in_port=%h map_valid=%b t=%0t",
                         in_port, map_valid, m_port, m_valid, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic wr(input logic [7:0] idx, input int addr, input logic [7:0] data);
        ioctl_wr    = 1'b1;
        ioctl_index = idx;
        ioctl_addr  = 25'(addr);
        ioctl_dout  = data;
        tick();
        ioctl_wr = 1'b0;
    endtask

    initial begin
        int cnt;
        joy = '1;
        #2 reset_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) tick();
        chk("reset in_port", 32'(in_port), 32'h0);
        chk("reset map_valid", 32'(map_valid), 32'h0);
        reset_n = 1'b1;
        repeat (4) tick();
        chk("idle no table", 32'(in_port), 32'h0);
        joy = '0;
        tick();

        wr(8'd2, 8, 8'h84);
        joy[4] = 1'b1;
        tick();
        chk("map lag", 32'(in_port[8]), 32'h0);
        tick();
        chk("map bit8", 32'(in_port[8]), 32'h1);
        wr(8'd2, 8, 8'hC4);
        tick();
        chk("map invert", 32'(in_port[8]), 32'h0);
        joy[4] = 1'b0;
        tick();
        tick();
        chk("map invert idle", 32'(in_port[8]), 32'h1);

        wr(8'd254, 0, 8'h5A);
        tick();
        chk("dip or", 32'(in_port[7:0]), 32'h5A);
        wr(8'd254, 3, 8'hFF);
        tick();
        chk("dip out of range", 32'(in_port), 32'h00015A);
        wr(8'd2, 24, 8'h80);
        tick();
        chk("map out of range", 32'(in_port), 32'h00015A);

        wr(8'd254, 0, 8'h00);
        wr(8'd2, 4, 8'h8A);
        joy[10] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) joy[10] = 1'b0;
            cnt += int'(in_port[4]);
        end
        chk("coin pulse", 32'(cnt), 32'd10);
        joy[10] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 19) joy[10] = 1'b0;
            cnt += int'(in_port[4]);
        end
        chk("coin hold", 32'(cnt), 32'd20);

        wr(8'd2, 1, 8'h80);
        wr(8'd2, 6, 8'h81);
        joy       = 32'h1;
        ctrl_mode = 1'b1;
        dir_state = 1'b1;
        tick();
        tick();
        chk("swap slots", 32'({in_port[6], in_port[1]}), SWAP ? 32'h2 : 32'h1);
        dir_state = 1'b0;
        tick();
        tick();
        chk("swap restored", 32'({in_port[6], in_port[1]}), 32'h1);
        ctrl_mode = 1'b0;

        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < NB - 1; a++) wr(8'd2, a, 8'($urandom));
        chk("valid partial", 32'(map_valid), 32'h0);
        wr(8'd2, NB - 1, 8'h00);
        chk("valid full", 32'(map_valid), 32'h1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int a = 0; a < 11; a++) wr(8'd2, a, 8'h80 | 8'(a));
        reset_n = 1'b0;
        #1;
        chk("reset mid-load valid", 32'(map_valid), 32'h0);
        chk("reset mid-load port", 32'(in_port), 32'h0);
        tick();
        reset_n = 1'b1;

        for (int c = 0; c < 3000; c++) begin
            ioctl_wr    = ($urandom_range(0, 3) == 0);
            ioctl_index = ($urandom_range(0, 2) == 0) ? 8'd254 : (($urandom_range(0, 4) == 0) ? 8'd7 : 8'd2);
            ioctl_addr  = 25'($urandom_range(0, 27));
            ioctl_dout  = 8'($urandom);
            joy         = ($urandom & ~SMASK) | (($urandom_range(0, 15) == 0) ? SMASK : (joy & SMASK & {32{$urandom_range(0, 1) == 1}}));
            if ($urandom_range(0, 15) == 0) begin
                ctrl_mode = 1'($urandom);
                dir_state = 1'($urandom);
            end
            reset_n = ($urandom_range(0, 699) != 0);
            tick();
        end
        ioctl_wr = 1'b0;
        reset_n  = 1'b1;
        tick();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
